// File: rtl/aes_round_sched.sv
// Iterative AES encryption sequencer: drives one shared full-round datapath NR-1 times,
// then the final (no mixColumns) round, then the last-key whitening, with valid/ready on both sides.
module aes_round_sched #(
    parameter int unsigned NR = 10,
    parameter int unsigned AW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_block,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_block,
    output logic          busy,
    output logic [AW-1:0] rk_addr,
    input  logic [127:0]  rk_data,
    output logic [127:0]  dp_state,
    output logic [127:0]  dp_key,
    input  logic [127:0]  dp_out,
    input  logic [127:0]  dp_last_out
);

    typedef enum logic [2:0] {
        StIdle,
        StRound,
        StFinal,
        StWhiten,
        StDone
    } state_e;

    localparam logic [AW-1:0] LastRoundCtr = AW'(NR - 2);
    localparam logic [AW-1:0] FinalAddr    = AW'(NR - 1);
    localparam logic [AW-1:0] WhitenAddr   = AW'(NR);

    state_e         fsm_q, fsm_d;
    logic [127:0]   state_q, state_d;
    logic [AW-1:0]  ctr_q, ctr_d;
    logic [127:0]   out_block_q, out_block_d;
    logic           out_valid_q, out_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            ctr_q       <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        ctr_d       = ctr_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        rk_addr     = '0;
        busy        = 1'b0;
        in_ready    = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                in_ready = key_valid;
            end
            StRound: begin
                busy    = 1'b1;
                rk_addr = ctr_q;
                state_d = dp_out;
                if (ctr_q == LastRoundCtr) begin
                    fsm_d = StFinal;
                end else begin
                    ctr_d = ctr_q + AW'(1);
                end
            end
            StFinal: begin
                busy    = 1'b1;
                rk_addr = FinalAddr;
                state_d = dp_last_out;
                fsm_d   = StWhiten;
            end
            StWhiten: begin
                busy        = 1'b1;
                rk_addr     = WhitenAddr;
                out_block_d = state_q ^ rk_data;
                out_valid_d = 1'b1;
                fsm_d       = StDone;
            end
            StDone: begin
                // Taking the ciphertext frees the slot for a new block in the same cycle.
                in_ready = key_valid & out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase

        if (in_valid && in_ready) begin
            state_d = in_block;
            ctr_d   = '0;
            fsm_d   = StRound;
        end
    end

    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign dp_state  = state_q;
    assign dp_key    = rk_data;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: behavioural AES round datapath and key store around
// the DUT, with a FIPS-197 style reference encryptor for expected ciphertexts.
module tb_aes_round_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data, dp_state, dp_key, dp_out, dp_last_out;

    logic [127:0] rk [0:10];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sched #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .in_valid(in_valid),
        .in_ready(in_ready), .in_block(in_block), .out_valid(out_valid),
        .out_ready(out_ready), .out_block(out_block), .busy(busy), .rk_addr(rk_addr),
        .rk_data(rk_data), .dp_state(dp_state), .dp_key(dp_key), .dp_out(dp_out),
        .dp_last_out(dp_last_out)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, s, r;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, a);
        end
        r = inv ^ 8'h63;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            s = {s[6:0], s[7]};
            r = r ^ s;
        end
        return r;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(getb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = getb(s, r + 4 * ((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = getb(s, 4*c); a1 = getb(s, 4*c+1); a2 = getb(s, 4*c+2); a3 = getb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    assign dp_out      = mix_columns(shift_rows(sub_bytes(dp_state ^ dp_key)));
    assign dp_last_out = shift_rows(sub_bytes(dp_state ^ dp_key));
    assign rk_data     = (rk_addr <= 4'd10) ? rk[rk_addr] : '0;

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
        return shift_rows(sub_bytes(s)) ^ rk[10];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for out_valid; starts in cycle T+1 and returns the cycle offset it rose at.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rk_addr !== 4'd0) begin errors++; $display("FAIL reset_rk_addr got %0d want 0", rk_addr); end
        checks++; if (out_block !== 128'h0) begin errors++; $display("FAIL reset_out_block got %h want 0", out_block); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_nokey got %b want 0", in_ready); end
        rst = 1'b0;
        key_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_key got %b want 1", in_ready); end
    endtask

    task automatic test_fips_c1();
        logic [127:0] want;
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        want = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_valid = 1'b1; in_block = 128'h00112233445566778899aabbccddeeff;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_accept got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_block = rnd128();
        for (int n = 1; n <= 12; n++) begin
            checks++;
            if (out_valid !== (n == 12)) begin
                errors++; $display("FAIL c1_out_valid cycle T+%0d got %b want %b", n, out_valid, n == 12);
            end
            if (n < 12) tick();
        end
        checks++; if (out_block !== want) begin errors++; $display("FAIL c1_ciphertext got %h want %h", out_block, want); end
        checks++; if (ref_encrypt(128'h00112233445566778899aabbccddeeff) !== want) begin
            errors++; $display("FAIL c1_reference_model got %h want %h", ref_encrypt(128'h00112233445566778899aabbccddeeff), want);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_handshake got %b want 0", out_valid); end
    endtask

    task automatic test_rk_trace();
        logic [127:0] blk;
        int exp_addr;
        load_key(rnd128());
        blk = rnd128();
        in_valid = 1'b1; in_block = blk;
        #1;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            exp_addr = (n <= 9) ? n - 1 : (n == 10) ? 9 : (n == 11) ? 10 : 0;
            checks++; if (rk_addr !== 4'(exp_addr)) begin errors++; $display("FAIL trace_rk_addr T+%0d got %0d want %0d", n, rk_addr, exp_addr); end
            checks++; if (busy !== (n <= 11)) begin errors++; $display("FAIL trace_busy T+%0d got %b want %b", n, busy, n <= 11); end
            checks++; if (dp_key !== rk[exp_addr]) begin errors++; $display("FAIL trace_dp_key T+%0d got %h want %h", n, dp_key, rk[exp_addr]); end
            if (n < 12) tick();
        end
        checks++; if (out_valid !== 1'b1 || out_block !== ref_encrypt(blk)) begin
            errors++; $display("FAIL trace_result valid %b got %h want %h", out_valid, out_block, ref_encrypt(blk));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] blk, held;
        int lat;
        blk = rnd128();
        in_valid = 1'b1; in_block = blk;
        #1;
        tick();
        in_block = rnd128();
        wait_out(lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL bp_latency got %0d want 12", lat); end
        held = ref_encrypt(blk);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready stall %0d got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_block !== held) begin
                errors++; $display("FAIL bp_hold stall %0d valid %b got %h want %h", i, out_valid, out_block, held);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_complete valid %b busy %b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b0, b1;
        logic [127:0] got [2];
        int oc [2];
        int ac, nout;
        b0 = rnd128(); b1 = rnd128();
        got[0] = '0; got[1] = '0; oc[0] = -1; oc[1] = -1;
        out_ready = 1'b1; in_valid = 1'b1; in_block = b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got %b want 1", in_ready); end
        tick();
        in_block = b1;
        nout = 0; ac = -1;
        for (int n = 1; n <= 40 && nout < 2; n++) begin
            #1;
            if (out_valid && out_ready) begin got[nout] = out_block; oc[nout] = n; nout++; end
            if (in_valid && in_ready) ac = n;
            tick();
            if (ac == n) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (nout !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nout); end
        checks++; if (oc[0] !== 12) begin errors++; $display("FAIL b2b_first_cycle got %0d want 12", oc[0]); end
        checks++; if (ac !== 12) begin errors++; $display("FAIL b2b_second_accept got %0d want 12", ac); end
        checks++; if (oc[1] !== 24) begin errors++; $display("FAIL b2b_second_cycle got %0d want 24", oc[1]); end
        checks++; if (got[0] !== ref_encrypt(b0)) begin errors++; $display("FAIL b2b_data0 got %h want %h", got[0], ref_encrypt(b0)); end
        checks++; if (got[1] !== ref_encrypt(b1)) begin errors++; $display("FAIL b2b_data1 got %h want %h", got[1], ref_encrypt(b1)); end
    endtask

    task automatic test_key_gating();
        logic [127:0] blk;
        int lat;
        load_key(rnd128());
        blk = rnd128();
        key_valid = 1'b0; in_valid = 1'b1; in_block = blk;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gate_in_ready %0d got %b want 0", i, in_ready); end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_no_accept %0d got busy %b want 0", i, busy); end
        end
        key_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gate_open got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_accepted got busy %b want 1", busy); end
        wait_out(lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL gate_latency got %0d want 12", lat); end
        checks++; if (out_block !== ref_encrypt(blk)) begin errors++; $display("FAIL gate_data got %h want %h", out_block, ref_encrypt(blk)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk;
        int lat, seen;
        in_valid = 1'b1; in_block = rnd128();
        #1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rk_addr !== 4'd0 || out_block !== 128'h0) begin
            errors++; $display("FAIL rstmid_state valid %b busy %b addr %0d blk %h want 0 0 0 0", out_valid, busy, rk_addr, out_block);
        end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_dropped got %0d valid cycles want 0", seen); end
        blk = rnd128();
        in_valid = 1'b1; in_block = blk;
        #1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL rstmid_latency got %0d want 12", lat); end
        checks++; if (out_block !== ref_encrypt(blk)) begin errors++; $display("FAIL rstmid_data got %h want %h", out_block, ref_encrypt(blk)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_rk_trace();
        test_backpressure();
        test_back_to_back();
        test_key_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
